// File: rtl/collatz_pkg.sv
// Shared types for the Collatz engine: FSM states and error codes.
package collatz_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE,
      ERR
   } stateT;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_ZERO = 2'd1;
   localparam logic [1:0] ERR_OVF  = 2'd2;
   localparam logic [1:0] ERR_SAT  = 2'd3;

endpackage

// File: rtl/collatz_engine_if.sv
// Start/abort handshake and result bus of the Collatz engine.
// Carries collatz_engine_peak_OutBUS when COLLATZ_ENGINE_MAXTRACK_EN is defined.
interface collatz_engine_if #(
   parameter int DATAWIDTH_BUS   = 8,
   parameter int DATAWIDTH_STEP  = 8,
   parameter int DATAWIDTH_ERROR = 2
);

   logic                       collatz_engine_start_InHigh;
   logic                       collatz_engine_abort_InHigh;
   logic [DATAWIDTH_BUS-1:0]   collatz_engine_data_InBUS;
   logic [DATAWIDTH_BUS-1:0]   collatz_engine_data_OutBUS;
   logic [DATAWIDTH_STEP-1:0]  collatz_engine_steps_OutBUS;
   logic                       collatz_engine_busy_OutHigh;
   logic                       collatz_engine_done_OutHigh;
   logic                       collatz_engine_error_OutHigh;
   logic [DATAWIDTH_ERROR-1:0] collatz_engine_errorcode_OutBUS;
   logic                       collatz_engine_zero_OutLow;
`ifdef COLLATZ_ENGINE_MAXTRACK_EN
   logic [DATAWIDTH_BUS-1:0]   collatz_engine_peak_OutBUS;
`endif

   modport master (
      output collatz_engine_start_InHigh,
      output collatz_engine_abort_InHigh,
      output collatz_engine_data_InBUS,
      input  collatz_engine_data_OutBUS,
      input  collatz_engine_steps_OutBUS,
      input  collatz_engine_busy_OutHigh,
      input  collatz_engine_done_OutHigh,
      input  collatz_engine_error_OutHigh,
      input  collatz_engine_errorcode_OutBUS,
`ifdef COLLATZ_ENGINE_MAXTRACK_EN
      input  collatz_engine_peak_OutBUS,
`endif
      input  collatz_engine_zero_OutLow
   );

   modport slave (
      input  collatz_engine_start_InHigh,
      input  collatz_engine_abort_InHigh,
      input  collatz_engine_data_InBUS,
      output collatz_engine_data_OutBUS,
      output collatz_engine_steps_OutBUS,
      output collatz_engine_busy_OutHigh,
      output collatz_engine_done_OutHigh,
      output collatz_engine_error_OutHigh,
      output collatz_engine_errorcode_OutBUS,
`ifdef COLLATZ_ENGINE_MAXTRACK_EN
      output collatz_engine_peak_OutBUS,
`endif
      output collatz_engine_zero_OutLow
   );

endinterface

// File: rtl/collatz_step_alu.sv
// One combinational Collatz step: v/2 when even, 3v+1 when odd,
// with the odd product formed two bits wider to expose overflow.
module collatz_step_alu #(
   parameter int DATAWIDTH_BUS = 8
) (
   input  logic [DATAWIDTH_BUS-1:0] value,
   output logic [DATAWIDTH_BUS-1:0] nextValue,
   output logic                     overflow,
   output logic                     isOne,
   output logic                     isZero
);

   localparam int WideW = DATAWIDTH_BUS + 2;

   logic [WideW-1:0] ext;
   logic [WideW-1:0] tripled;
   logic [WideW-1:0] halved;
   logic [WideW-1:0] wide;

   always_comb begin
      ext     = WideW'(value);
      tripled = ext + (ext << 1) + WideW'(1);
      halved  = ext >> 1;
      wide    = value[0] ? tripled : halved;
   end

   assign nextValue = wide[DATAWIDTH_BUS-1:0];
   assign overflow  = |wide[WideW-1:DATAWIDTH_BUS];
   assign isOne     = (value == DATAWIDTH_BUS'(1));
   assign isZero    = (value == '0);

endmodule

// File: rtl/collatz_engine.sv
// Self-sequenced Collatz engine: FSM, step counter and result registers.
// Optional peak tracking under COLLATZ_ENGINE_MAXTRACK_EN.
module collatz_engine
   import collatz_pkg::*;
#(
   parameter int DATAWIDTH_BUS   = 8,
   parameter int DATAWIDTH_STEP  = 8,
   parameter int DATAWIDTH_ERROR = 2
) (
   input logic              collatz_engine_CLOCK_50,
   input logic              collatz_engine_RESET_InHigh,
   collatz_engine_if.slave  bus
);

   logic clk;
   logic rst;
   assign clk = collatz_engine_CLOCK_50;
   assign rst = collatz_engine_RESET_InHigh;

   stateT state;
   stateT nextState;

   logic [DATAWIDTH_BUS-1:0]   value;
   logic [DATAWIDTH_STEP-1:0]  steps;
   logic [DATAWIDTH_ERROR-1:0] errCode;

   logic [DATAWIDTH_BUS-1:0]   aluNext;
   logic                       aluOvf;
   logic                       aluOne;
   logic                       aluZero;

   logic                       loadStart;
   logic                       commitStep;
   logic                       setCode;
   logic [DATAWIDTH_ERROR-1:0] codeNext;

   collatz_step_alu #(
      .DATAWIDTH_BUS (DATAWIDTH_BUS)
   ) stepAlu (
      .value     (value),
      .nextValue (aluNext),
      .overflow  (aluOvf),
      .isOne     (aluOne),
      .isZero    (aluZero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // RUN priority: abort, finished, zero, saturation, overflow, step
   always_comb begin
      nextState  = state;
      loadStart  = 1'b0;
      commitStep = 1'b0;
      setCode    = 1'b0;
      codeNext   = DATAWIDTH_ERROR'(ERR_NONE);
      unique case (state)
         IDLE: begin
            if (bus.collatz_engine_start_InHigh) begin
               loadStart = 1'b1;
               nextState = RUN;
            end
         end
         RUN: begin
            if (bus.collatz_engine_abort_InHigh) begin
               nextState = IDLE;
            end else if (aluOne) begin
               nextState = DONE;
            end else if (aluZero) begin
               setCode   = 1'b1;
               codeNext  = DATAWIDTH_ERROR'(ERR_ZERO);
               nextState = ERR;
            end else if (steps == '1) begin
               setCode   = 1'b1;
               codeNext  = DATAWIDTH_ERROR'(ERR_SAT);
               nextState = ERR;
            end else if (aluOvf) begin
               setCode   = 1'b1;
               codeNext  = DATAWIDTH_ERROR'(ERR_OVF);
               nextState = ERR;
            end else begin
               commitStep = 1'b1;
            end
         end
         DONE: nextState = IDLE;
         ERR:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value   <= '0;
         steps   <= '0;
         errCode <= '0;
      end else if (loadStart) begin
         value   <= bus.collatz_engine_data_InBUS;
         steps   <= '0;
         errCode <= '0;
      end else if (commitStep) begin
         value   <= aluNext;
         steps   <= steps + 1'b1;
      end else if (setCode) begin
         errCode <= codeNext;
      end
   end

`ifdef COLLATZ_ENGINE_MAXTRACK_EN
   logic [DATAWIDTH_BUS-1:0] peak;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak <= '0;
      end else if (loadStart) begin
         peak <= bus.collatz_engine_data_InBUS;
      end else if (commitStep && (aluNext > peak)) begin
         peak <= aluNext;
      end
   end

   assign bus.collatz_engine_peak_OutBUS = peak;
`endif

   assign bus.collatz_engine_data_OutBUS      = value;
   assign bus.collatz_engine_steps_OutBUS     = steps;
   assign bus.collatz_engine_errorcode_OutBUS = errCode;
   assign bus.collatz_engine_busy_OutHigh     = (state == RUN);
   assign bus.collatz_engine_done_OutHigh     = (state == DONE);
   assign bus.collatz_engine_error_OutHigh    = (state == ERR);
   assign bus.collatz_engine_zero_OutLow      = (value != '0);

endmodule

// File: tb/tb_collatz_engine.sv
// Directed bench for collatz_engine at three parameter sets.
// Peak checks apply when COLLATZ_ENGINE_MAXTRACK_EN is defined.
module tb_collatz_engine;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;

   collatz_engine_if #(
      .DATAWIDTH_BUS(8), .DATAWIDTH_STEP(8), .DATAWIDTH_ERROR(2)
   ) ifA ();
   collatz_engine_if #(
      .DATAWIDTH_BUS(8), .DATAWIDTH_STEP(3), .DATAWIDTH_ERROR(2)
   ) ifB ();
   collatz_engine_if #(
      .DATAWIDTH_BUS(16), .DATAWIDTH_STEP(8), .DATAWIDTH_ERROR(2)
   ) ifC ();

   collatz_engine #(
      .DATAWIDTH_BUS(8), .DATAWIDTH_STEP(8), .DATAWIDTH_ERROR(2)
   ) dutA (
      .collatz_engine_CLOCK_50     (clk),
      .collatz_engine_RESET_InHigh (rst),
      .bus                         (ifA)
   );
   collatz_engine #(
      .DATAWIDTH_BUS(8), .DATAWIDTH_STEP(3), .DATAWIDTH_ERROR(2)
   ) dutB (
      .collatz_engine_CLOCK_50     (clk),
      .collatz_engine_RESET_InHigh (rst),
      .bus                         (ifB)
   );
   collatz_engine #(
      .DATAWIDTH_BUS(16), .DATAWIDTH_STEP(8), .DATAWIDTH_ERROR(2)
   ) dutC (
      .collatz_engine_CLOCK_50     (clk),
      .collatz_engine_RESET_InHigh (rst),
      .bus                         (ifC)
   );

   logic [31:0] vVal[3];
   logic [31:0] vSteps[3];
   logic [31:0] vCode[3];
   logic        vBusy[3];
   logic        vDone[3];
   logic        vErr[3];
   logic        vZeroN[3];

   assign vVal[0]   = 32'(ifA.collatz_engine_data_OutBUS);
   assign vVal[1]   = 32'(ifB.collatz_engine_data_OutBUS);
   assign vVal[2]   = 32'(ifC.collatz_engine_data_OutBUS);
   assign vSteps[0] = 32'(ifA.collatz_engine_steps_OutBUS);
   assign vSteps[1] = 32'(ifB.collatz_engine_steps_OutBUS);
   assign vSteps[2] = 32'(ifC.collatz_engine_steps_OutBUS);
   assign vCode[0]  = 32'(ifA.collatz_engine_errorcode_OutBUS);
   assign vCode[1]  = 32'(ifB.collatz_engine_errorcode_OutBUS);
   assign vCode[2]  = 32'(ifC.collatz_engine_errorcode_OutBUS);
   assign vBusy[0]  = ifA.collatz_engine_busy_OutHigh;
   assign vBusy[1]  = ifB.collatz_engine_busy_OutHigh;
   assign vBusy[2]  = ifC.collatz_engine_busy_OutHigh;
   assign vDone[0]  = ifA.collatz_engine_done_OutHigh;
   assign vDone[1]  = ifB.collatz_engine_done_OutHigh;
   assign vDone[2]  = ifC.collatz_engine_done_OutHigh;
   assign vErr[0]   = ifA.collatz_engine_error_OutHigh;
   assign vErr[1]   = ifB.collatz_engine_error_OutHigh;
   assign vErr[2]   = ifC.collatz_engine_error_OutHigh;
   assign vZeroN[0] = ifA.collatz_engine_zero_OutLow;
   assign vZeroN[1] = ifB.collatz_engine_zero_OutLow;
   assign vZeroN[2] = ifC.collatz_engine_zero_OutLow;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx, input logic st,
                        input logic ab, input logic [31:0] d);
      case (idx)
         0: begin
            ifA.collatz_engine_start_InHigh = st;
            ifA.collatz_engine_abort_InHigh = ab;
            ifA.collatz_engine_data_InBUS   = d[7:0];
         end
         1: begin
            ifB.collatz_engine_start_InHigh = st;
            ifB.collatz_engine_abort_InHigh = ab;
            ifB.collatz_engine_data_InBUS   = d[7:0];
         end
         default: begin
            ifC.collatz_engine_start_InHigh = st;
            ifC.collatz_engine_abort_InHigh = ab;
            ifC.collatz_engine_data_InBUS   = d[15:0];
         end
      endcase
   endtask

   task automatic startOp(input int idx, input logic [31:0] d);
      drive(idx, 1'b1, 1'b0, d);
      tick();
      drive(idx, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic waitEnd(input int idx, input int budget,
                          output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!(vDone[idx] || vErr[idx]) && cycles < budget);
      check("end_within_budget", 32'(vDone[idx] || vErr[idx]), 32'd1);
   endtask

   int seq6[8] = '{3, 10, 5, 16, 8, 4, 2, 1};
   int busyCnt;
   int cyc;

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0);
      drive(2, 1'b0, 1'b0, 32'd0);
      tick();
      check("rst_value", vVal[0], 32'd0);
      check("rst_steps", vSteps[0], 32'd0);
      check("rst_code", vCode[0], 32'd0);
      check("rst_busy", 32'(vBusy[0]), 32'd0);
      check("rst_done", 32'(vDone[0]), 32'd0);
      check("rst_err", 32'(vErr[0]), 32'd0);
      check("rst_zeroN", 32'(vZeroN[0]), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // n=6: full sequence, busy length, ignored starts in RUN and DONE
      startOp(0, 32'd6);
      check("n6_busy0", 32'(vBusy[0]), 32'd1);
      check("n6_load", vVal[0], 32'd6);
      busyCnt = 1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) drive(0, 1'b1, 1'b0, 32'd99);
         tick();
         if (i == 3) drive(0, 1'b0, 1'b0, 32'd0);
         if (vBusy[0]) busyCnt++;
         check("n6_seq", vVal[0], 32'(seq6[i]));
         check("n6_steps", vSteps[0], 32'(i + 1));
      end
      tick();
      check("n6_done", 32'(vDone[0]), 32'd1);
      check("n6_busy_off", 32'(vBusy[0]), 32'd0);
      check("n6_busy_len", 32'(busyCnt), 32'd9);
      check("n6_steps_final", vSteps[0], 32'd8);
      check("n6_code", vCode[0], 32'd0);
`ifdef COLLATZ_ENGINE_MAXTRACK_EN
      check("n6_peak", 32'(ifA.collatz_engine_peak_OutBUS), 32'd16);
`endif
      drive(0, 1'b1, 1'b0, 32'd5);
      tick();
      drive(0, 1'b0, 1'b0, 32'd0);
      check("n6_done_pulse", 32'(vDone[0]), 32'd0);
      check("n6_start_in_done", 32'(vBusy[0]), 32'd0);
      check("n6_hold_value", vVal[0], 32'd1);
      tick();
      check("n6_still_idle", 32'(vBusy[0]), 32'd0);

      // n=27 at 8 bits: overflow at 107
      startOp(0, 32'd27);
      waitEnd(0, 40, cyc);
      check("n27_err", 32'(vErr[0]), 32'd1);
      check("n27_code", vCode[0], 32'd2);
      check("n27_value", vVal[0], 32'd107);
      check("n27_steps", vSteps[0], 32'd11);
      check("n27_latency", 32'(cyc), 32'd12);
      tick();
      check("n27_err_pulse", 32'(vErr[0]), 32'd0);
      check("n27_code_hold", vCode[0], 32'd2);

      // n=0: zero error one cycle after RUN entry
      startOp(0, 32'd0);
      check("n0_busy", 32'(vBusy[0]), 32'd1);
      check("n0_code_clr", vCode[0], 32'd0);
      check("n0_zeroN", 32'(vZeroN[0]), 32'd0);
      tick();
      check("n0_err", 32'(vErr[0]), 32'd1);
      check("n0_code", vCode[0], 32'd1);
      check("n0_steps", vSteps[0], 32'd0);

      // n=1: done two edges after start, zero steps
      tick();
      startOp(0, 32'd1);
      check("n1_no_done_yet", 32'(vDone[0]), 32'd0);
      tick();
      check("n1_done", 32'(vDone[0]), 32'd1);
      check("n1_steps", vSteps[0], 32'd0);
      check("n1_code", vCode[0], 32'd0);
      check("n1_zeroN", 32'(vZeroN[0]), 32'd1);

      // 3-bit step counter: saturation at value 2
      startOp(1, 32'd6);
      waitEnd(1, 30, cyc);
      check("sat_err", 32'(vErr[1]), 32'd1);
      check("sat_code", vCode[1], 32'd3);
      check("sat_steps", vSteps[1], 32'd7);
      check("sat_value", vVal[1], 32'd2);
      check("sat_latency", 32'(cyc), 32'd8);

      // 16-bit: abort after five steps, then a full run
      startOp(2, 32'd27);
      for (int i = 0; i < 5; i++) tick();
      drive(2, 1'b0, 1'b1, 32'd0);
      tick();
      drive(2, 1'b0, 1'b0, 32'd0);
      check("abort_busy", 32'(vBusy[2]), 32'd0);
      check("abort_done", 32'(vDone[2]), 32'd0);
      check("abort_err", 32'(vErr[2]), 32'd0);
      check("abort_steps", vSteps[2], 32'd5);
      check("abort_value", vVal[2], 32'd31);
      check("abort_code", vCode[2], 32'd0);
      tick();
      check("abort_no_pulse", 32'(vDone[2] || vErr[2]), 32'd0);
      startOp(2, 32'd27);
      waitEnd(2, 200, cyc);
      check("w16_done", 32'(vDone[2]), 32'd1);
      check("w16_steps", vSteps[2], 32'd111);
      check("w16_value", vVal[2], 32'd1);
      check("w16_latency", 32'(cyc), 32'd112);
`ifdef COLLATZ_ENGINE_MAXTRACK_EN
      check("w16_peak", 32'(ifC.collatz_engine_peak_OutBUS), 32'd9232);
`endif

      // asynchronous reset in the middle of RUN
      tick();
      startOp(2, 32'd27);
      tick();
      tick();
      check("pre_rst_busy", 32'(vBusy[2]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(vBusy[2]), 32'd0);
      check("arst_value", vVal[2], 32'd0);
      check("arst_steps", vSteps[2], 32'd0);
      check("arst_zeroN", 32'(vZeroN[2]), 32'd0);
      check("arst_a_value", vVal[0], 32'd0);
`ifdef COLLATZ_ENGINE_MAXTRACK_EN
      check("arst_peak", 32'(ifC.collatz_engine_peak_OutBUS), 32'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_idle", 32'(vBusy[2]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/collatz_engine.md
Name: collatz_engine

Overview:
- Self-sequenced, parametrised Collatz datapath.
- Accepts a start operand over a start handshake, then iterates one Collatz step per clock: n even -> n/2, n odd -> 3n+1. Stops at n==1 and reports the step count.
- Detects zero input, arithmetic overflow and step-counter saturation.
- Replaces the externally driven mux/ALU/shifter datapath plus an external controller with a single block that has its own FSM, handshake and result registers.

Parameters:
- DATAWIDTH_BUS, 8, operand/value width in bits (>=4).
- DATAWIDTH_STEP, 8, step-counter width in bits (>=2).
- DATAWIDTH_ERROR, 2, error-code width (fixed encoding, do not change).

Ports:
- collatz_engine_CLOCK_50  in  1  single clock, rising edge.
- collatz_engine_RESET_InHigh  in  1  asynchronous, active-high reset.
- collatz_engine_start_InHigh  in  1  start request; sampled only in IDLE.
- collatz_engine_abort_InHigh  in  1  synchronous abort of a running computation.
- collatz_engine_data_InBUS  in  DATAWIDTH_BUS  start operand; captured with an accepted start.
- collatz_engine_data_OutBUS  out  DATAWIDTH_BUS  current value register (live).
- collatz_engine_steps_OutBUS  out  DATAWIDTH_STEP  step count.
- collatz_engine_busy_OutHigh  out  1  high while in RUN.
- collatz_engine_done_OutHigh  out  1  one-cycle pulse on successful completion.
- collatz_engine_error_OutHigh  out  1  one-cycle pulse on error termination.
- collatz_engine_errorcode_OutBUS  out  DATAWIDTH_ERROR  0 none, 1 zero input, 2 overflow, 3 step saturation.
- collatz_engine_zero_OutLow  out  1  low when the value register equals 0.

Behaviour:
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, value=0, steps=0, errorcode=0, busy=0, done=0, error=0.
  - zero_OutLow=0, because value==0.
- FSM states: IDLE, RUN, DONE, ERR. All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- IDLE:
  - start=1 at an edge: value<=data_In, steps<=0, errorcode<=0, go to RUN.
  - start=0: stay; value, steps and errorcode hold the last results.
- RUN (busy=1), evaluated each edge, first match wins:
  1. abort=1 -> IDLE; value and steps frozen; no done or error pulse; errorcode unchanged (0).
  2. value==1 -> DONE.
  3. value==0 -> errorcode<=1, go to ERR.
  4. A step is required but steps==all-ones -> errorcode<=3, go to ERR; value unchanged.
  5. Odd value: 3v+1 is computed at DATAWIDTH_BUS+2 bits. If the upper two bits are nonzero -> errorcode<=2, go to ERR; value and steps unchanged. Otherwise value<=low bits, steps<=steps+1.
  6. Even value: value<=v>>1, steps<=steps+1.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. Start is not accepted in DONE.
- ERR: error=1 for exactly one cycle, then IDLE. Errorcode holds until the next accepted start or reset.
- Start while in RUN, DONE or ERR is ignored, with no queuing.
- Latency: for an operand needing k steps, start is accepted at edge 0, the final step lands at edge k, DONE is entered at edge k+1, and done is high in the cycle after edge k+1.
  - n=1 gives k=0: done high after edge 1, steps=0.
- Steps never wrap; saturation is always reported as error 3.

Optional Feature:
- Macro COLLATZ_ENGINE_MAXTRACK_EN.
- When defined:
  - Extra output collatz_engine_peak_OutBUS (DATAWIDTH_BUS).
  - Peak register loads data_In on an accepted start and takes max(peak, new value) on every committed step.
  - Reset value is 0; held after termination until the next start.
- When undefined: no port, no register, no logic.

Decomposition:
- Package collatz_pkg holds:
  - state enum (IDLE, RUN, DONE, ERR);
  - error-code constants (ERR_NONE=0, ERR_ZERO=1, ERR_OVF=2, ERR_SAT=3).
- One combinational sub-module, collatz_step_alu, parametrised by DATAWIDTH_BUS.
  - Inputs: value.
  - Outputs: next value, overflow flag, is_one, is_zero.
- The FSM, step counter and result registers stay in collatz_engine.

Test Plan:
- Defaults, n=6 -> value sequence 3,10,5,16,8,4,2,1; done pulse with steps=8, errorcode=0; busy high exactly 9 cycles. With MAXTRACK: peak=16.
- Defaults, n=27 -> after 11 steps value=107; 3*107+1=322 overflows -> error pulse, errorcode=2, value=107, steps=11.
- Defaults, n=0 -> error pulse one cycle after RUN entry, errorcode=1, steps=0. Also n=1 -> done with steps=0, two cycles after the start edge.
- DATAWIDTH_STEP=3, n=6 -> after 7 steps value=2 -> error, errorcode=3, steps=7.
- Start n=27 with DATAWIDTH_BUS=16, abort after 5 cycles -> IDLE, no pulses, steps=5. A new start with n=27 then completes with steps=111 (peak 9232 under MAXTRACK).
- Reset asserted mid-RUN asynchronously, plus start pulsed during RUN and DONE -> all outputs return to reset values immediately; ignored starts cause no state change.
